// File: rtl/systolic_result_drain.sv
// Result collector for the 3x3 systolic array: waits out the compute latency,
// snapshots the nine cell accumulators and streams them row-major over valid/ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               one-cycle pulse on the first skewed operand beat
//   cell_1..cell_9      array results, row-major (cell_1 = C[0][0])
//   busy                high whenever the collector is not idle
//   acc_clr             one-cycle pulse asking the array to clear its accumulators
//   out_data/out_idx    current result word and its row*3+col index
//   out_valid/out_ready handshake; a word moves on an edge with both high
//   out_last            marks the word with index 8
//   done                one-cycle pulse after the last word is accepted
module systolic_result_drain #(
    parameter int data_width     = 8,
    parameter int COMPUTE_CYCLES = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*data_width:0] cell_1,
    input  logic [2*data_width:0] cell_2,
    input  logic [2*data_width:0] cell_3,
    input  logic [2*data_width:0] cell_4,
    input  logic [2*data_width:0] cell_5,
    input  logic [2*data_width:0] cell_6,
    input  logic [2*data_width:0] cell_7,
    input  logic [2*data_width:0] cell_8,
    input  logic [2*data_width:0] cell_9,
    output logic                  busy,
    output logic                  acc_clr,
    output logic [2*data_width:0] out_data,
    output logic [3:0]            out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done
);

    localparam int RW = 2*data_width+1;
    localparam logic [7:0] CNT_LOAD = 8'(COMPUTE_CYCLES-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [RW-1:0]   snap_q [9];
    logic [RW-1:0]   cell_w [9];
    logic            cap;
    logic [RW-1:0]   data_q, data_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0]      idx_nxt;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            clr_q, clr_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    assign cell_w[0] = cell_1;
    assign cell_w[1] = cell_2;
    assign cell_w[2] = cell_3;
    assign cell_w[3] = cell_4;
    assign cell_w[4] = cell_5;
    assign cell_w[5] = cell_6;
    assign cell_w[6] = cell_7;
    assign cell_w[7] = cell_8;
    assign cell_w[8] = cell_9;

    assign idx_nxt = idx_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    // Word 0 comes straight from the inputs because the
                    // snapshot is being written on this same edge.
                    cap     = 1'b1;
                    state_d = S_DRAIN;
                    idx_d   = 4'd0;
                    data_d  = cell_w[0];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    clr_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DRAIN: begin
                if (valid_q && out_ready) begin
                    if (idx_q == 4'd8) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = snap_q[idx_nxt];
                        last_d = (idx_nxt == 4'd8);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            data_q  <= '0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            if (cap) begin
                for (int i = 0; i < 9; i++) begin
                    snap_q[i] <= cell_w[i];
                end
            end
        end
    end

    assign busy      = busy_q;
    assign acc_clr   = clr_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: latency, drain order, stalls,
// ignored starts, mid-drain reset, back-to-back runs and extreme latencies.
module tb_systolic_result_drain;

    localparam int W = 17;

    logic         clk = 1'b0;
    logic         rst;
    logic         st [3];
    logic         rdy;
    logic [W-1:0] c [9];

    logic         bz [3];
    logic         clr [3];
    logic [W-1:0] od [3];
    logic [3:0]   oi [3];
    logic         ov [3];
    logic         ol [3];
    logic         dn [3];

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] ev_mat [9] = '{98, 106, 90, 124, 124, 108, 105, 111, 83};
    logic [W-1:0] ev_seq [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    logic [W-1:0] ev_max [9];
    int           ma [3][3] = '{'{7, 4, 7}, '{5, 6, 9}, '{1, 9, 5}};
    int           mb [3][3] = '{'{2, 5, 3}, '{7, 9, 5}, '{8, 5, 7}};

    always #5 clk = ~clk;

    systolic_result_drain #(.data_width(8), .COMPUTE_CYCLES(7)) u_d7 (
        .clk(clk), .rst(rst), .start(st[0]),
        .cell_1(c[0]), .cell_2(c[1]), .cell_3(c[2]),
        .cell_4(c[3]), .cell_5(c[4]), .cell_6(c[5]),
        .cell_7(c[6]), .cell_8(c[7]), .cell_9(c[8]),
        .busy(bz[0]), .acc_clr(clr[0]), .out_data(od[0]),
        .out_idx(oi[0]), .out_valid(ov[0]), .out_ready(rdy),
        .out_last(ol[0]), .done(dn[0])
    );

    systolic_result_drain #(.data_width(8), .COMPUTE_CYCLES(1)) u_d1 (
        .clk(clk), .rst(rst), .start(st[1]),
        .cell_1(c[0]), .cell_2(c[1]), .cell_3(c[2]),
        .cell_4(c[3]), .cell_5(c[4]), .cell_6(c[5]),
        .cell_7(c[6]), .cell_8(c[7]), .cell_9(c[8]),
        .busy(bz[1]), .acc_clr(clr[1]), .out_data(od[1]),
        .out_idx(oi[1]), .out_valid(ov[1]), .out_ready(rdy),
        .out_last(ol[1]), .done(dn[1])
    );

    systolic_result_drain #(.data_width(8), .COMPUTE_CYCLES(255)) u_d255 (
        .clk(clk), .rst(rst), .start(st[2]),
        .cell_1(c[0]), .cell_2(c[1]), .cell_3(c[2]),
        .cell_4(c[3]), .cell_5(c[4]), .cell_6(c[5]),
        .cell_7(c[6]), .cell_8(c[7]), .cell_9(c[8]),
        .busy(bz[2]), .acc_clr(clr[2]), .out_data(od[2]),
        .out_idx(oi[2]), .out_valid(ov[2]), .out_ready(rdy),
        .out_last(ol[2]), .done(dn[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic set_mat();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                int s = 0;
                for (int j = 0; j < 3; j++) begin
                    s += ma[r][j] * mb[j][k];
                end
                c[r*3+k] = W'(s);
            end
        end
    endtask

    task automatic set_seq();
        for (int i = 0; i < 9; i++) begin
            c[i] = W'(i+1);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge
    // following the capture edge.
    task automatic wait_cap(input int d, input int lat, input int re_at);
        int n;
        rdy   = 1'b0;
        st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
        n = 1;
        chk("busy_after_start", 32'(bz[d]), 1);
        while (!ov[d] && n < 300) begin
            if (n == re_at) begin
                st[d] = 1'b1;
            end
            @(negedge clk);
            st[d] = 1'b0;
            n++;
        end
        chk("cap_latency", n-1, lat);
        chk("cap_idx0", 32'(oi[d]), 0);
        chk("cap_busy", 32'(bz[d]), 1);
    endtask

    // mode 0: ready always high; mode 1: ready 1,0,0 pattern and cells
    // zeroed one cycle after capture. st_at: cycle to pulse start (-1 none).
    task automatic drain(input int d, input logic [W-1:0] ev [9],
                         input int mode, input int st_at);
        int k   = 0;
        int cyc = 0;
        while (k < 9 && cyc < 100) begin
            chk("valid", 32'(ov[d]), 1);
            chk("data", 32'(od[d]), 32'(ev[k]));
            chk("idx", 32'(oi[d]), k);
            chk("last", 32'(ol[d]), 32'(k == 8));
            chk("acc_clr", 32'(clr[d]), 32'(cyc == 0));
            chk("no_done", 32'(dn[d]), 0);
            rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (mode == 1 && cyc == 0) begin
                for (int i = 0; i < 9; i++) begin
                    c[i] = '0;
                end
            end
            if (cyc == st_at) begin
                st[d] = 1'b1;
            end
            @(negedge clk);
            st[d] = 1'b0;
            if (rdy) begin
                k++;
            end
            cyc++;
        end
        chk("word_count", k, 9);
        chk("done_pulse", 32'(dn[d]), 1);
        chk("done_valid", 32'(ov[d]), 0);
        chk("done_last", 32'(ol[d]), 0);
        chk("done_busy", 32'(bz[d]), 1);
        rdy = 1'b0;
        @(negedge clk);
        chk("done_drop", 32'(dn[d]), 0);
        chk("idle_busy", 32'(bz[d]), 0);
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
        end
        for (int i = 0; i < 9; i++) begin
            c[i]      = '0;
            ev_max[i] = 17'h1FFFF;
        end
        #1;
        chk("rst_busy", 32'(bz[0]), 0);
        chk("rst_valid", 32'(ov[0]), 0);
        chk("rst_last", 32'(ol[0]), 0);
        chk("rst_done", 32'(dn[0]), 0);
        chk("rst_clr", 32'(clr[0]), 0);
        chk("rst_data", 32'(od[0]), 0);
        chk("rst_idx", 32'(oi[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Matrix product, full throughput.
        set_mat();
        wait_cap(0, 7, 0);
        drain(0, ev_mat, 0, -1);

        // Back-to-back: start in the single idle cycle; starts during
        // WAIT and DRAIN must be ignored; stalls and cell changes.
        set_seq();
        wait_cap(0, 7, 3);
        drain(0, ev_seq, 1, 2);
        @(negedge clk);
        chk("stay_idle", 32'(bz[0]), 0);

        // Reset in the middle of draining.
        set_seq();
        wait_cap(0, 7, 0);
        rdy = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_idx", 32'(oi[0]), 4);
        chk("pre_rst_data", 32'(od[0]), 5);
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(ov[0]), 0);
        chk("arst_busy", 32'(bz[0]), 0);
        chk("arst_idx", 32'(oi[0]), 0);
        chk("arst_data", 32'(od[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", 32'(dn[0]), 0);
            chk("post_rst_valid", 32'(ov[0]), 0);
            chk("post_rst_busy", 32'(bz[0]), 0);
        end
        set_mat();
        wait_cap(0, 7, 0);
        drain(0, ev_mat, 0, -1);

        // Latency extremes with saturated cells.
        for (int i = 0; i < 9; i++) begin
            c[i] = 17'h1FFFF;
        end
        wait_cap(1, 1, 0);
        drain(1, ev_max, 0, -1);
        wait_cap(2, 255, 0);
        drain(2, ev_max, 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
